// File: rtl/adder_pkg.sv
// Shared constants and types for the exact 16-bit lookahead adder.
package adder_pkg;

    localparam int ADD_W = 16;
    localparam int GRP_W = 4;
    localparam int N_GRP = 4;

    typedef logic [15:0] word_t;

endpackage : adder_pkg

// File: rtl/cla_4.sv
// 4-bit carry-lookahead group: every internal carry is a flat sum of products
// from c0, plus group generate/propagate for the second-level unit.
module cla_4
    import adder_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             c0,
    output logic [GRP_W-1:0] s,
    output logic             G,
    output logic             P
);

    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    logic [GRP_W-1:0] c;

    // Per-bit generate/propagate, flat lookahead carries and group terms.
    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);

        s = p ^ c;

        G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
        P = &p;
    end

endmodule : cla_4

// File: rtl/cla_16_4.sv
// Exact 16-bit two-level carry-lookahead adder: four cla_4 groups plus an
// inline group-carry unit, with an optional one-cycle output register.
module cla_16_4
    import adder_pkg::*;
#(
    parameter int WIDTH   = ADD_W,
    parameter int GRP_W   = adder_pkg::GRP_W,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [N_GRP-1:0] grp_g;
    logic [N_GRP-1:0] grp_p;
    logic [N_GRP-1:0] grp_c;
    logic             carry_out;
    word_t            sum_c;

    // Second-level lookahead: each group carry is fully expanded from cin so
    // no group carry depends on another group carry.
    always_comb begin
        grp_c[0]  = cin;
        grp_c[1]  = grp_g[0] | (grp_p[0] & cin);
        grp_c[2]  = grp_g[1] | (grp_p[1] & grp_g[0])
                  | (grp_p[1] & grp_p[0] & cin);
        grp_c[3]  = grp_g[2] | (grp_p[2] & grp_g[1])
                  | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
        carry_out = grp_g[3] | (grp_p[3] & grp_g[2])
                  | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
    end

    for (genvar k = 0; k < N_GRP; k++) begin : g_grp
        cla_4 u_grp (
            .a  (a[k*GRP_W +: GRP_W]),
            .b  (b[k*GRP_W +: GRP_W]),
            .c0 (grp_c[k]),
            .s  (sum_c[k*GRP_W +: GRP_W]),
            .G  (grp_g[k]),
            .P  (grp_p[k])
        );
    end

    if (REG_OUT) begin : g_reg
        // Register the result; reset forces zero and wins over new operands.
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum  <= '0;
                cout <= 1'b0;
            end else begin
                sum  <= sum_c;
                cout <= carry_out;
            end
        end
    end else begin : g_comb
        // Clock and reset are intentionally ignored in the zero-latency build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk & rst;
        assign sum  = sum_c;
        assign cout = carry_out;
    end

endmodule : cla_16_4

// File: tb/tb_cla_16_4.sv
// Self-checking bench for cla_16_4: a combinational instance checked against
// plain integer addition, and a registered instance checked every cycle
// against a one-cycle-delayed arithmetic model with synchronous reset.
module tb_cla_16_4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [15:0] a0 = '0, b0 = '0;
    logic        cin0 = 1'b0;
    logic [15:0] sum0;
    logic        cout0;

    logic [15:0] a1 = '0, b1 = '0;
    logic        cin1 = 1'b0;
    logic [15:0] sum1;
    logic        cout1;

    int n_total = 0;
    int n_pass  = 0;

    // Registered-instance model state.
    logic [16:0] exp_reg;
    bit          exp_valid = 1'b0;
    bit          done = 1'b0;

    cla_16_4 #(.REG_OUT(1'b0)) dut_comb (
        .clk (clk), .rst (rst), .a (a0), .b (b0), .cin (cin0),
        .sum (sum0), .cout (cout0)
    );

    cla_16_4 #(.REG_OUT(1'b1)) dut_reg (
        .clk (clk), .rst (rst), .a (a1), .b (b1), .cin (cin1),
        .sum (sum1), .cout (cout1)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_add(logic [15:0] x, logic [15:0] y, logic c);
        return {1'b0, x} + {1'b0, y} + {16'd0, c};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got {cout,sum}=%05h expected %05h", name, act, exp);
    endtask

    // Drive the combinational instance and check against a literal value.
    task automatic comb_lit(input string name, input logic [15:0] x, input logic [15:0] y,
                            input logic c, input logic [16:0] exp);
        a0 = x; b0 = y; cin0 = c;
        #1;
        check(name, {cout0, sum0}, exp);
    endtask

    // Model of the registered instance: result of the operands present at the
    // edge, or zero while reset is held.
    always @(posedge clk) begin
        exp_reg   <= rst ? 17'd0 : ref_add(a1, b1, cin1);
        exp_valid <= 1'b1;
    end

    // Compare the registered instance every cycle, away from the edge.
    always @(negedge clk) begin
        if (exp_valid && !done) check("reg_stream", {cout1, sum1}, exp_reg);
    end

    initial begin
        logic [15:0] x, y;
        logic        c;

        // Combinational instance: hand-computed vectors.
        comb_lit("zero",        16'h0000, 16'h0000, 1'b0, 17'h0_0000);
        comb_lit("basic",       16'h1234, 16'h4321, 1'b0, 17'h0_5555);
        comb_lit("full_prop",   16'hFFFF, 16'h0000, 1'b1, 17'h1_0000);
        comb_lit("full_prop0",  16'hFFFF, 16'h0000, 1'b0, 17'h0_FFFF);
        comb_lit("msb_carry",   16'h8000, 16'h8000, 1'b0, 17'h1_0000);
        comb_lit("grp_bound",   16'h0F0F, 16'h00F1, 1'b0, 17'h0_1000);
        comb_lit("max",         16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
        comb_lit("alt_prop",    16'hAAAA, 16'h5555, 1'b1, 17'h1_0000);

        // Combinational instance: random vectors, including reset toggling
        // which must have no effect on it.
        for (int i = 0; i < 3000; i++) begin
            x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
            if (i % 7 == 0) x = 16'hFFFF ^ y;
            a0 = x; b0 = y; cin0 = c;
            if (i % 100 == 0) rst = ~rst;
            #1;
            check("comb_rand", {cout0, sum0}, ref_add(x, y, c));
        end

        // Registered instance: hold reset with operands that would carry out.
        @(posedge clk); #1;
        rst = 1'b1; a1 = 16'hFFFF; b1 = 16'h0001; cin1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reg_in_reset", {cout1, sum1}, 17'h0_0000);

        // Release reset: the next edge captures FFFF+0001.
        #1; rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reg_release", {cout1, sum1}, 17'h1_0000);

        // Back-to-back random operands, one per cycle, with a reset pulse.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            a1 = 16'($urandom); b1 = 16'($urandom); cin1 = 1'($urandom);
            rst = (i >= 200 && i < 203);
        end
        @(posedge clk); #1;
        a1 = 16'h1234; b1 = 16'h4321; cin1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reg_last", {cout1, sum1}, 17'h0_5555);

        #1 done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_cla_16_4
